// File: rtl/round_key_sequencer.sv
// DES round-key sequencer: expands a 64-bit DES key into the sixteen 48-bit
// PC-2 subkeys, issued one per valid/ready handshake in encrypt order
// (K1..K16) or decrypt order (K16..K1).
module round_key_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [1:64] key_64,
    input  logic        key_ready,
    output logic [1:48] round_key,
    output logic        key_valid,
    output logic [3:0]  round_idx,
    output logic [3:0]  sub_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PREP  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    // PC-1: source key bit (FIPS numbering) for each C/D bit position 1..56.
    localparam logic [6:0] PC1_TAB [1:56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    // PC-2: source C/D bit position for each subkey bit 1..48.
    localparam logic [5:0] PC2_TAB [1:48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] r;
        for (int unsigned i = 32'd1; i <= 32'd56; i++) begin
            r[i] = k[PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] r;
        for (int unsigned i = 32'd1; i <= 32'd48; i++) begin
            r[i] = cd[PC2_TAB[i]];
        end
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 rotate by one place, all others by two.
    // Argument is the zero-based subkey number (Kn -> n-1).
    function automatic logic shift_one(input logic [3:0] sub);
        logic r;
        case (sub)
            4'd0, 4'd1, 4'd8, 4'd15: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

    // Rotate each 28-bit half towards bit 1 by one or two places.
    function automatic logic [1:56] rot_l(input logic [1:56] cd, input logic one);
        logic [1:28] c;
        logic [1:28] d;
        c = cd[1:28];
        d = cd[29:56];
        if (one) begin
            c = {c[2:28], c[1]};
            d = {d[2:28], d[1]};
        end else begin
            c = {c[3:28], c[1:2]};
            d = {d[3:28], d[1:2]};
        end
        return {c, d};
    endfunction

    // Rotate each 28-bit half away from bit 1 by one or two places.
    function automatic logic [1:56] rot_r(input logic [1:56] cd, input logic one);
        logic [1:28] c;
        logic [1:28] d;
        c = cd[1:28];
        d = cd[29:56];
        if (one) begin
            c = {c[28], c[1:27]};
            d = {d[28], d[1:27]};
        end else begin
            c = {c[27:28], c[1:26]};
            d = {d[27:28], d[1:26]};
        end
        return {c, d};
    endfunction

    state_t      state_r;
    logic [1:56] cd_r;
    logic        decrypt_r;
    logic [1:48] round_key_r;
    logic        key_valid_r;
    logic [3:0]  round_idx_r;
    logic [3:0]  sub_idx_r;
    logic        busy_r;
    logic        done_r;
    logic [1:56] prep_cd_s;
    logic [1:56] next_cd_s;

    // C/D value for the first key, and for the key after the current Kn.
    always_comb begin
        prep_cd_s = cd_r;
        next_cd_s = cd_r;
        if (decrypt_r) begin
            prep_cd_s = cd_r;
            next_cd_s = rot_r(cd_r, shift_one(sub_idx_r));
        end else begin
            prep_cd_s = rot_l(cd_r, 1'b1);
            next_cd_s = rot_l(cd_r, shift_one(sub_idx_r + 4'd1));
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cd_r        <= 56'd0;
            decrypt_r   <= 1'b0;
            round_key_r <= 48'd0;
            key_valid_r <= 1'b0;
            round_idx_r <= 4'd0;
            sub_idx_r   <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    // The done cycle is still part of the finished sequence.
                    if (start && !done_r) begin
                        cd_r      <= pc1(key_64);
                        decrypt_r <= decrypt;
                        busy_r    <= 1'b1;
                        state_r   <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    cd_r        <= prep_cd_s;
                    round_key_r <= pc2(prep_cd_s);
                    sub_idx_r   <= decrypt_r ? 4'd15 : 4'd0;
                    round_idx_r <= 4'd0;
                    key_valid_r <= 1'b1;
                    state_r     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (key_ready) begin
                        if (round_idx_r == 4'd15) begin
                            key_valid_r <= 1'b0;
                            done_r      <= 1'b1;
                            round_key_r <= 48'd0;
                            round_idx_r <= 4'd0;
                            sub_idx_r   <= 4'd0;
                            busy_r      <= 1'b0;
                            state_r     <= ST_IDLE;
                        end else begin
                            cd_r        <= next_cd_s;
                            round_key_r <= pc2(next_cd_s);
                            sub_idx_r   <= decrypt_r ? (sub_idx_r - 4'd1) : (sub_idx_r + 4'd1);
                            round_idx_r <= round_idx_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    key_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign round_key = round_key_r;
    assign key_valid = key_valid_r;
    assign round_idx = round_idx_r;
    assign sub_idx   = sub_idx_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Testbench for round_key_sequencer: directed FIPS vectors, stalls, ignored
// starts, mid-sequence reset and random keys against a DES key-schedule model.
module tb_round_key_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key_64;
    logic        key_ready;
    logic [47:0] round_key;
    logic        key_valid;
    logic [3:0]  round_idx;
    logic [3:0]  sub_idx;
    logic        busy;
    logic        done;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [47:0] got_q [16];
    logic [47:0] enc_q [16];

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    round_key_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .decrypt   (decrypt),
        .key_64    (key_64),
        .key_ready (key_ready),
        .round_key (round_key),
        .key_valid (key_valid),
        .round_idx (round_idx),
        .sub_idx   (sub_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standard DES key schedule: Kn from the cumulative left-shift total.
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int n);
        int pc1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                         19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                         14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
        int pc2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                         41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] r;
        int t;
        for (int i = 1; i <= 56; i++) cd[56 - i] = k[64 - pc1[i - 1]];
        t = 0;
        for (int j = 1; j <= n; j++) t += (j == 1 || j == 2 || j == 9 || j == 16) ? 1 : 2;
        t = t % 28;
        c = cd[55:28];
        d = cd[27:0];
        c = (c << t) | (c >> (28 - t));
        d = (d << t) | (d >> (28 - t));
        cd = {c, d};
        for (int i = 1; i <= 48; i++) r[48 - i] = cd[56 - pc2[i - 1]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a sequence and check the two-cycle latency to the first key.
    task automatic begin_seq(input logic [63:0] k, input logic dec);
        start = 1'b1;
        key_64 = k;
        decrypt = dec;
        key_ready = 1'b0;
        tick();
        start = 1'b0;
        key_64 = {$urandom, $urandom};
        decrypt = ~dec;
        vec_cnt++;
        if (key_valid !== 1'b0 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL prep_cycle: key_valid=%b busy=%b, required 0 1", key_valid, busy);
        end
        tick();
        vec_cnt++;
        if (key_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL first_key_latency: key_valid=%b, required 1", key_valid);
        end
    endtask

    // Issue loop: checks every cycle against the model, records accepted keys.
    task automatic issue_seq(input logic [63:0] k, input logic dec, input bit stall, input bit poke);
        int hs = 0;
        int cyc = 0;
        int sub;
        logic rdy;
        bit poked = 0;
        while (hs < 16 && cyc < 200) begin
            rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            key_ready = rdy;
            key_64 = {$urandom, $urandom};
            decrypt = $urandom_range(0, 1);
            start = 1'b0;
            if (poke && hs == 5 && !poked) begin
                start = 1'b1;
                poked = 1;
            end
            sub = dec ? 15 - hs : hs;
            vec_cnt++;
            if (key_valid !== 1'b1 || round_key !== ref_subkey(k, sub + 1) || round_idx !== hs[3:0] ||
                sub_idx !== sub[3:0] || busy !== 1'b1 || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL issue pos=%0d: key=%h idx=%0d sub=%0d valid=%b busy=%b done=%b, required key=%h idx=%0d sub=%0d 1 1 0",
                         hs, round_key, round_idx, sub_idx, key_valid, busy, done, ref_subkey(k, sub + 1), hs, sub);
            end
            if (rdy) begin
                got_q[hs] = round_key;
                hs++;
            end
            tick();
            cyc++;
        end
        key_ready = 1'b0;
        start = 1'b0;
        vec_cnt++;
        if (hs < 16) begin
            err_cnt++;
            $display("FAIL handshake_timeout: handshakes=%0d, required 16", hs);
        end
        vec_cnt++;
        if (done !== 1'b1 || key_valid !== 1'b0 || round_key !== 48'd0 || round_idx !== 4'd0 ||
            sub_idx !== 4'd0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL done_cycle: done=%b valid=%b key=%h idx=%0d sub=%0d busy=%b, required 1 0 0 0 0 0",
                     done, key_valid, round_key, round_idx, sub_idx, busy);
        end
    endtask

    task automatic finish_seq();
        tick();
        vec_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || key_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL after_done: done=%b busy=%b valid=%b, required 0 0 0", done, busy, key_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        decrypt = 1'b0;
        key_64 = KEY_A;
        key_ready = 1'b1;
        repeat (3) tick();
        vec_cnt++;
        if (round_key !== 48'd0 || key_valid !== 1'b0 || round_idx !== 4'd0 ||
            sub_idx !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_state: key=%h valid=%b idx=%0d sub=%0d busy=%b done=%b, required all 0",
                     round_key, key_valid, round_idx, sub_idx, busy, done);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            vec_cnt++;
            if (key_valid !== 1'b0 || busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", key_valid, busy);
            end
        end
    endtask

    task automatic test_known_encrypt();
        begin_seq(KEY_A, 1'b0);
        issue_seq(KEY_A, 1'b0, 0, 0);
        vec_cnt++;
        if (got_q[0] !== 48'h1B02EFFC7072 || got_q[1] !== 48'h79AED9DBC9E5 || got_q[15] !== 48'hCB3D8B0E17F5) begin
            err_cnt++;
            $display("FAIL fips_encrypt: K1=%h K2=%h K16=%h, required 1b02effc7072 79aed9dbc9e5 cb3d8b0e17f5",
                     got_q[0], got_q[1], got_q[15]);
        end
        finish_seq();
    endtask

    task automatic test_known_decrypt();
        begin_seq(KEY_A, 1'b1);
        issue_seq(KEY_A, 1'b1, 0, 0);
        vec_cnt++;
        if (got_q[0] !== 48'hCB3D8B0E17F5 || got_q[1] !== 48'hBF918D3D3F0A || got_q[15] !== 48'h1B02EFFC7072) begin
            err_cnt++;
            $display("FAIL fips_decrypt: first=%h second=%h last=%h, required cb3d8b0e17f5 bf918d3d3f0a 1b02effc7072",
                     got_q[0], got_q[1], got_q[15]);
        end
        finish_seq();
    endtask

    task automatic test_stalls();
        begin_seq(KEY_A, 1'b0);
        issue_seq(KEY_A, 1'b0, 1, 0);
        finish_seq();
    endtask

    task automatic test_start_ignored();
        logic [63:0] kb;
        kb = {$urandom, $urandom};
        begin_seq(KEY_A, 1'b0);
        issue_seq(KEY_A, 1'b0, 1, 1);
        start = 1'b1;
        key_64 = kb;
        decrypt = 1'b1;
        tick();
        vec_cnt++;
        if (busy !== 1'b0 || key_valid !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL start_in_done_cycle: busy=%b valid=%b done=%b, required 0 0 0", busy, key_valid, done);
        end
        begin_seq(kb, 1'b1);
        issue_seq(kb, 1'b1, 0, 0);
        finish_seq();
    endtask

    task automatic test_reset_mid();
        begin_seq(KEY_A, 1'b0);
        key_ready = 1'b1;
        repeat (7) tick();
        key_ready = 1'b0;
        vec_cnt++;
        if (round_idx !== 4'd7) begin
            err_cnt++;
            $display("FAIL reach_idx7: idx=%0d, required 7", round_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (round_key !== 48'd0 || key_valid !== 1'b0 || round_idx !== 4'd0 ||
            sub_idx !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_reset_mid: key=%h valid=%b idx=%0d sub=%0d busy=%b done=%b, required all 0",
                     round_key, key_valid, round_idx, sub_idx, busy, done);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            vec_cnt++;
            if (key_valid !== 1'b0 || busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL no_valid_after_reset: valid=%b busy=%b, required 0 0", key_valid, busy);
            end
        end
        begin_seq(KEY_A, 1'b0);
        issue_seq(KEY_A, 1'b0, 0, 0);
        vec_cnt++;
        if (got_q[0] !== 48'h1B02EFFC7072 || got_q[15] !== 48'hCB3D8B0E17F5) begin
            err_cnt++;
            $display("FAIL restart_after_reset: K1=%h K16=%h, required 1b02effc7072 cb3d8b0e17f5", got_q[0], got_q[15]);
        end
        finish_seq();
    endtask

    task automatic test_random_keys();
        logic [63:0] k;
        for (int r = 0; r < 5; r++) begin
            k = {$urandom, $urandom};
            begin_seq(k, 1'b0);
            issue_seq(k, 1'b0, 1, 0);
            for (int i = 0; i < 16; i++) enc_q[i] = got_q[i];
            finish_seq();
            begin_seq(k, 1'b1);
            issue_seq(k, 1'b1, 1, 0);
            for (int i = 0; i < 16; i++) begin
                vec_cnt++;
                if (got_q[i] !== enc_q[15 - i]) begin
                    err_cnt++;
                    $display("FAIL reverse_order key=%h pos=%0d: decrypt=%h, required %h", k, i, got_q[i], enc_q[15 - i]);
                end
            end
            finish_seq();
        end
    endtask

    initial begin
        test_reset();
        test_known_encrypt();
        test_known_decrypt();
        test_stalls();
        test_start_ignored();
        test_reset_mid();
        test_random_keys();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/round_key_sequencer.md
ROUND_KEY_SEQUENCER -- requirements
Module: round_key_sequencer

Interface
REQ-001 Parameters: none; all widths are fixed by DES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new 16-round key sequence; sampled only in IDLE.
REQ-005 decrypt  input  1  direction, sampled with start: 0 = K1..K16, 1 = K16..K1.
REQ-006 key_64  input  [1:64]  DES key, bit 1 = MSB (FIPS numbering); parity bits ignored; sampled with start.
REQ-007 key_ready  input  1  consumer accepts round_key this cycle.
REQ-008 round_key  output  [1:48]  registered PC-2 subkey, bit 1 = MSB.
REQ-009 key_valid  output  1  round_key/round_idx/sub_idx are valid.
REQ-010 round_idx  output  4  issue position minus 1 (0..15).
REQ-011 sub_idx  output  4  DES subkey number minus 1 (Kn -> n-1).
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the 16th handshake.

Function
REQ-014 States: IDLE, PREP, ISSUE; encoding is free.
REQ-015 IDLE & start: latch C,D = PC-1(key_64) halves (28 bits each); latch decrypt; -> PREP.
REQ-016 Shift table s(n) = 1 for n in {1,2,9,16}, else 2; all rotations are within each 28-bit half.
REQ-017 PREP, encrypt: CD <= rotl(CD, s(1)); round_key <= PC-2(rotl(CD, s(1))); sub_idx <= 0.
REQ-018 PREP, decrypt: CD unchanged (C16D16 = C0D0); round_key <= PC-2(CD); sub_idx <= 15.
REQ-019 PREP: round_idx <= 0; key_valid <= 1; -> ISSUE. First key is visible 2 cycles after start is sampled.
REQ-020 ISSUE without key_ready: all outputs and state are held stable.
REQ-021 ISSUE & key_ready & round_idx<15, encrypt with current Kn: CD <= rotl(CD, s(n+1)); round_key <= PC-2 of the new CD; sub_idx +1; round_idx +1; key_valid stays 1.
REQ-022 ISSUE & key_ready & round_idx<15, decrypt with current Kn: CD <= rotr(CD, s(n)); round_key <= PC-2 of the new CD; sub_idx -1; round_idx +1; key_valid stays 1.
REQ-023 With key_ready held high, one key is issued per cycle and the 16 keys occupy 16 consecutive cycles.
REQ-024 ISSUE & key_ready & round_idx=15: key_valid <= 0; done <= 1 for one cycle; round_key, round_idx, sub_idx <= 0; -> IDLE.
REQ-025 start while busy, including the done cycle: ignored; key_64 and decrypt changes while busy have no effect.
REQ-026 start in the cycle after done: accepted normally.
REQ-027 After 16 rounds in either direction the net rotation is 28, so CD equals the PC-1 value.

Reset
REQ-028 rst_n low, at any time including mid-sequence: state = IDLE; round_key, round_idx, sub_idx, CD = 0; key_valid, busy, done = 0; asynchronous.
REQ-029 After rst_n deasserts: no key_valid until a new start.

Verification
REQ-030 Key 0x133457799BBCDFF1, encrypt, key_ready=1: keys appear on cycles T+2..T+17; K1=0x1B02EFFC7072, K2=0x79AED9DBC9E5, K16=0xCB3D8B0E17F5; done on T+18.
REQ-031 Same key, decrypt: first key 0xCB3D8B0E17F5 with sub_idx=15, second 0xBF918D3D3F0A, last 0x1B02EFFC7072 with sub_idx=0.
REQ-032 Random key_ready stalls: key sequence identical to REQ-030; outputs stable while key_ready=0; exactly 16 handshakes, then done.
REQ-033 start pulsed at round_idx=5 and in the done cycle: no effect; start on the next cycle: new sequence begins normally.
REQ-034 rst_n low at round_idx=7: all outputs 0 immediately; restart after reset reproduces REQ-030.
REQ-035 Golden model: random keys, both directions; decrypt sequence equals the encrypt sequence reversed.
